// File: rtl/mips_io_pkg.sv
// Shared register map and bit positions for the MEM-stage I/O responder.
// Offsets are word indices (Address[7:2]), so byte offset 0x14 becomes index 5.
package mips_io_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF0000;

   localparam logic [5:0] OFS_PORT_OUT = 6'h00;
   localparam logic [5:0] OFS_PORT_IN  = 6'h01;
   localparam logic [5:0] OFS_STATUS   = 6'h02;
   localparam logic [5:0] OFS_TLOAD    = 6'h03;
   localparam logic [5:0] OFS_TCOUNT   = 6'h04;
   localparam logic [5:0] OFS_CTRL     = 6'h05;

   localparam int STS_CHG = 0;
   localparam int STS_EXP = 1;

   localparam int CTRL_TEN    = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IE_CHG = 2;
   localparam int CTRL_IE_EXP = 3;

endpackage

// File: rtl/io_timer.sv
// Down-counter with one-shot or auto-reload expiry; count updates one edge after its inputs.
// No backpressure: a load strobe always wins over a decrement or reload that cycle.
module io_timer #(
   parameter int TIMER_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_i,
   input  logic [TIMER_WIDTH-1:0] load_val_i,
   input  logic [TIMER_WIDTH-1:0] reload_val_i,
   input  logic                   en_i,
   input  logic                   auto_i,
   output logic [TIMER_WIDTH-1:0] count_o,
   output logic                   expire_o,
   output logic                   en_clr_o
);

   localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);

   logic [TIMER_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d  = count_q;
      expire_o = en_i && (count_q == '0);
      en_clr_o = expire_o && !auto_i;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         // Expiry at zero means the decrement can never wrap.
         if (count_q != '0) begin
            count_d = count_q - ONE;
         end else if (auto_i) begin
            count_d = reload_val_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mips_io_responder.sv
// Memory-mapped I/O block beside DataMemory: output port, synchronized input port, timer.
// Reads are combinational (zero latency), writes land at the edge; never stalls the pipeline.
module mips_io_responder
   import mips_io_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          TIMER_WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic        Select,
   output logic [31:0] ReadData,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic        IRQ
);

   logic [31:0]            port_out_q, port_out_d;
   logic [7:0]             sync1_q, in_sync_q, in_prev_q;
   logic [1:0]             status_q, status_d;
   logic [TIMER_WIDTH-1:0] tload_q, tload_d;
   logic [3:0]             ctrl_q, ctrl_d;

   logic [TIMER_WIDTH-1:0] tmr_count;
   logic                   tmr_expire, tmr_en_clr;

   logic [5:0]  ofs;
   logic        wr, rd, chg_set;
   logic        wr_port_out, wr_status, wr_tload, wr_ctrl;
   logic [31:0] rdata;
   logic        unused_ok;

   assign Select    = (Address[31:8] == BASE_ADDR[31:8]);
   assign ofs       = Address[7:2];
   assign unused_ok = &{1'b0, Address[1:0]};
   assign wr        = Select && MemWrite;
   assign rd        = Select && MemRead;

   assign wr_port_out = wr && (ofs == OFS_PORT_OUT);
   assign wr_status   = wr && (ofs == OFS_STATUS);
   assign wr_tload    = wr && (ofs == OFS_TLOAD);
   assign wr_ctrl     = wr && (ofs == OFS_CTRL);

   assign chg_set = (in_sync_q != in_prev_q);

   io_timer #(
      .TIMER_WIDTH (TIMER_WIDTH)
   ) u_timer (
      .clk          (clk),
      .reset        (reset),
      .load_i       (wr_tload),
      .load_val_i   (TIMER_WIDTH'(WriteData)),
      .reload_val_i (tload_q),
      .en_i         (ctrl_q[CTRL_TEN]),
      .auto_i       (ctrl_q[CTRL_AUTO]),
      .count_o      (tmr_count),
      .expire_o     (tmr_expire),
      .en_clr_o     (tmr_en_clr)
   );

   always_comb begin
      port_out_d = wr_port_out ? WriteData : port_out_q;
      tload_d    = wr_tload ? TIMER_WIDTH'(WriteData) : tload_q;

      // A hardware set event beats a same-edge write-1-to-clear.
      status_d[STS_CHG] = chg_set ||
                          (status_q[STS_CHG] && !(wr_status && WriteData[STS_CHG]));
      status_d[STS_EXP] = tmr_expire ||
                          (status_q[STS_EXP] && !(wr_status && WriteData[STS_EXP]));

      ctrl_d = ctrl_q;
      if (wr_ctrl) begin
         ctrl_d = WriteData[3:0];
      end else if (tmr_en_clr) begin
         ctrl_d[CTRL_TEN] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         port_out_q <= '0;
         sync1_q    <= '0;
         in_sync_q  <= '0;
         in_prev_q  <= '0;
         status_q   <= '0;
         tload_q    <= '0;
         ctrl_q     <= '0;
      end else begin
         port_out_q <= port_out_d;
         sync1_q    <= PortIn;
         in_sync_q  <= sync1_q;
         in_prev_q  <= in_sync_q;
         status_q   <= status_d;
         tload_q    <= tload_d;
         ctrl_q     <= ctrl_d;
      end
   end

   // Reads reflect pre-edge state, so a simultaneous store is not yet visible.
   always_comb begin
      rdata = '0;
      unique case (ofs)
         OFS_PORT_OUT: rdata = port_out_q;
         OFS_PORT_IN:  rdata = {24'b0, in_sync_q};
         OFS_STATUS:   rdata = {30'b0, status_q};
         OFS_TLOAD:    rdata = 32'(tload_q);
         OFS_TCOUNT:   rdata = 32'(tmr_count);
         OFS_CTRL:     rdata = {28'b0, ctrl_q};
         default:      rdata = '0;
      endcase
   end

   assign ReadData = rd ? rdata : '0;
   assign PortOut  = port_out_q;
   assign IRQ      = (status_q[STS_CHG] && ctrl_q[CTRL_IE_CHG]) ||
                     (status_q[STS_EXP] && ctrl_q[CTRL_IE_EXP]);

endmodule
